// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator (counters, blanking, strobes, frame count, delayed syncs)
//   clk_in      system clock
//   rst_in      synchronous reset, active-high
//   pix_ce      one-cycle strobe when new raster values appear
//   raster_x    horizontal position 0..H_TOTAL-1
//   raster_y    vertical position 0..V_TOTAL-1
//   active      low while the raster is in the visible area, high in blanking
//   line_start  pulse with raster_x becoming 0
//   frame_start pulse with raster becoming (0,0)
//   frame_count frames started since reset, wraps
//   hsync_out   horizontal sync, SYNC_POL polarity, delayed SYNC_DELAY clocks
//   vsync_out   vertical sync, SYNC_POL polarity, delayed SYNC_DELAY clocks
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIX_DIV    = 1,
    parameter bit SYNC_POL   = 1'b0,
    parameter int SYNC_DELAY = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    output logic       pix_ce,
    output logic [9:0] raster_x,
    output logic [9:0] raster_y,
    output logic       active,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count,
    output logic       hsync_out,
    output logic       vsync_out
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
    localparam int SD = SYNC_DELAY > 0 ? SYNC_DELAY : 1;
    localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
    // Window bounds are 11 bits so a sync pulse ending exactly at a 1024 total still compares correctly
    localparam logic [10:0] H_VIS = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS = 11'(V_VISIBLE);
    localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DW-1:0] div_q, div_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic [10:0] xe, ye;
    logic tick, x_wrap, act_d, hs_d, vs_d;
    logic pix_ce_q, act_q, ls_q, fs_q, hs_q, vs_q;
    logic [7:0] fc_q;
    logic [SD-1:0] hs_dl_q, vs_dl_q;

    always_comb begin
        tick   = div_q == DW'(PIX_DIV - 1);
        div_d  = tick ? '0 : div_q + 1'b1;
        x_wrap = x_q == H_MAX;
        x_d    = x_wrap ? '0 : x_q + 10'd1;
        y_d    = x_wrap ? (y_q == V_MAX ? '0 : y_q + 10'd1) : y_q;
        xe     = {1'b0, x_d};
        ye     = {1'b0, y_d};
        act_d  = !(xe < H_VIS && ye < V_VIS);
        hs_d   = (xe >= HS_BEG && xe < HS_END) ? SYNC_POL : ~SYNC_POL;
        // y only moves when x wraps, so vsync edges always line up with x==0
        vs_d   = (ye >= VS_BEG && ye < VS_END) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            div_q    <= '0;
            x_q      <= H_MAX;
            y_q      <= V_MAX;
            pix_ce_q <= 1'b0;
            act_q    <= 1'b1;
            ls_q     <= 1'b0;
            fs_q     <= 1'b0;
            fc_q     <= '0;
            hs_q     <= ~SYNC_POL;
            vs_q     <= ~SYNC_POL;
            hs_dl_q  <= {SD{~SYNC_POL}};
            vs_dl_q  <= {SD{~SYNC_POL}};
        end else begin
            div_q    <= div_d;
            pix_ce_q <= tick;
            ls_q     <= tick && x_d == '0;
            fs_q     <= tick && x_d == '0 && y_d == '0;
            if (tick) begin
                x_q   <= x_d;
                y_q   <= y_d;
                act_q <= act_d;
                hs_q  <= hs_d;
                vs_q  <= vs_d;
                if (x_d == '0 && y_d == '0) fc_q <= fc_q + 8'd1;
            end
            // Delay line runs on every clock, independent of the pixel divider
            hs_dl_q <= SD'({hs_dl_q, hs_q});
            vs_dl_q <= SD'({vs_dl_q, vs_q});
        end
    end

    assign pix_ce      = pix_ce_q;
    assign raster_x    = x_q;
    assign raster_y    = y_q;
    assign active      = act_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_count = fc_q;
    assign hsync_out   = SYNC_DELAY == 0 ? hs_q : hs_dl_q[SD-1];
    assign vsync_out   = SYNC_DELAY == 0 ? vs_q : vs_dl_q[SD-1];
endmodule
